// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences the shared datapath
// through fetch/decode/execute/memory/write-back and flags unsupported opcodes.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_zero,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM4 = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_IOP   = 2'd3;

  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_R_EXEC, ST_R_WB, ST_I_EXEC, ST_I_WB, ST_BRANCH, ST_JUMP
  } state_t;

  state_t state_q, state_d;

  logic       fetch_q, decode_q, jump_q;
  logic       fetch_d, decode_d, jump_d;
  logic       pc_write_cond_d, branch_ne_d, iord_d, mem_read_d, mem_write_d;
  logic       reg_dst_d, mem_to_reg_d, reg_write_d, alu_src_a_d, ext_zero_d;
  logic [1:0] alu_src_b_d, alu_op_d, pc_source_d;
  logic       legal_c, zext_c;

  // Opcode classification; the IR holds opcode stable from DECODE onwards
  always_comb begin
    legal_c = 1'b0;
    zext_c  = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: legal_c = 1'b1;
      OP_ANDI, OP_ORI: begin
        legal_c = 1'b1;
        zext_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = ST_R_EXEC;
          OP_LW, OP_SW:                      state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = ST_BRANCH;
          OP_J:                              state_d = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_I_EXEC;
          default:                           state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Moore outputs decoded from the next state so they land in flops aligned with state_q
  always_comb begin
    fetch_d         = 1'b0;
    decode_d        = 1'b0;
    jump_d          = 1'b0;
    pc_write_cond_d = 1'b0;
    branch_ne_d     = 1'b0;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    reg_dst_d       = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = SRCB_B;
    alu_op_d        = ALU_ADD;
    pc_source_d     = 2'd0;
    ext_zero_d      = 1'b0;
    case (state_d)
      ST_FETCH: begin
        fetch_d     = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_b_d = SRCB_4;
      end
      ST_DECODE: begin
        decode_d    = 1'b1;
        alu_src_b_d = SRCB_IMM4;
      end
      ST_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      ST_I_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRCB_IMM;
        alu_op_d    = ALU_IOP;
        ext_zero_d  = zext_c;
      end
      ST_I_WB: begin
        reg_write_d = 1'b1;
        ext_zero_d  = zext_c;
      end
      ST_BRANCH: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = ALU_SUB;
        pc_source_d     = PCS_ALUOUT;
        pc_write_cond_d = 1'b1;
        branch_ne_d     = (opcode == OP_BNE);
      end
      ST_JUMP: begin
        jump_d      = 1'b1;
        pc_source_d = PCS_JUMP;
      end
      default: ;
    endcase
  end

  // State and output registers; reset lands directly in FETCH with its output values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      fetch_q       <= 1'b1;
      decode_q      <= 1'b0;
      jump_q        <= 1'b0;
      pc_write_cond <= 1'b0;
      branch_ne     <= 1'b0;
      i_or_d        <= 1'b0;
      mem_read      <= 1'b1;
      mem_write     <= 1'b0;
      reg_dst       <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= SRCB_4;
      alu_op        <= ALU_ADD;
      pc_source     <= 2'd0;
      ext_zero      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_q       <= fetch_d;
      decode_q      <= decode_d;
      jump_q        <= jump_d;
      pc_write_cond <= pc_write_cond_d;
      branch_ne     <= branch_ne_d;
      i_or_d        <= iord_d;
      mem_read      <= mem_read_d;
      mem_write     <= mem_write_d;
      reg_dst       <= reg_dst_d;
      mem_to_reg    <= mem_to_reg_d;
      reg_write     <= reg_write_d;
      alu_src_a     <= alu_src_a_d;
      alu_src_b     <= alu_src_b_d;
      alu_op        <= alu_op_d;
      pc_source     <= pc_source_d;
      ext_zero      <= ext_zero_d;
    end
  end

  // Fetch completion and the illegal flag depend on same-cycle mem_ready / IR contents
  assign ir_write   = rst_n & fetch_q & mem_ready;
  assign pc_write   = rst_n & ((fetch_q & mem_ready) | jump_q);
  assign illegal_op = decode_q & ~legal_c;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle variant of the MIPS core. Sequences the shared datapath (single memory port, single ALU, immediate extender, register file) through fetch, decode, execute, memory and write-back steps per instruction. Drives every datapath select and enable as a Moore output of the current state, including the sign/zero select of the immediate extender. Stalls on memory handshake and flags unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from instruction register
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true
- branch_ne  out  1  branch condition is "not equal" (bne), else "equal"
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=ext(imm), 3=ext(imm)<<2
- alu_op  out  2  0=add, 1=sub, 2=funct, 3=from opcode (I-type)
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- ext_zero  out  1  immediate extender: 0=sign-extend, 1=zero-extend
- illegal_op  out  1  one-cycle pulse on unsupported opcode

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- All outputs are pure functions of state (Moore); outputs not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; ir_write=pc_write=mem_ready. Stay while mem_ready=0; go to DECODE when 1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0, ext_zero=0 (branch target). Next by opcode: 0x00->R_EXEC; 0x23 lw, 0x2B sw->MEM_ADDR; 0x04 beq, 0x05 bne->BRANCH; 0x02 j->JUMP; 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori->I_EXEC; anything else->FETCH with illegal_op=1 during DECODE.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0, ext_zero=0. lw->MEM_RD, sw->MEM_WR (opcode held stable by IR).
- MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
- MEM_WR: mem_write=1, i_or_d=1; wait for mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2; ->R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=3; ext_zero=1 for andi/ori, 0 for addi/slti; ->I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, ext_zero as in I_EXEC; ->FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_write_cond=1, branch_ne=(opcode==0x05); ->FETCH.
- JUMP: pc_write=1, pc_source=2; ->FETCH.

## Timing
- rst_n low: state=FETCH immediately (asynchronous); all outputs take FETCH values, so mem_read=1, alu_src_b=1, every other output 0 (pc_write/ir_write 0 until mem_ready). Reset mid-instruction abandons it; no partial write-back after release.
- Cycles per instruction with mem_ready held 1: R-type 4, I-type 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle; request signals stay asserted and stable while waiting.
- mem_ready ignored in all other states.
- illegal_op high exactly one cycle (DECODE); no reg_write, mem_write or pc_write for that instruction beyond the FETCH PC+4.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 -> state FETCH, mem_read=1, reg_write=0, mem_write=0, pc_write=0 while asserted; first FETCH after release asserts pc_write=ir_write=1.
- add (opcode 0x00), mem_ready=1 -> FETCH,DECODE,R_EXEC,R_WB; reg_write=1 with reg_dst=1 only in cycle 4; back in FETCH cycle 5.
- lw 0x23 with mem_ready low 2 cycles in MEM_RD -> 7-cycle instruction; mem_read, i_or_d=1 stable during wait; reg_write, mem_to_reg=1 one cycle.
- ori 0x0D then addi 0x08 -> ext_zero=1 in I_EXEC/I_WB for ori, 0 for addi; DECODE always ext_zero=0, alu_src_b=3.
- bne 0x05 and j 0x02 -> 3 cycles each; pc_write_cond=1, branch_ne=1, pc_source=1 for bne; pc_write=1, pc_source=2 for j.
- opcode 0x3F -> illegal_op pulse one cycle in DECODE, return to FETCH; no reg_write/mem_write asserted.
